// File: rtl/input_conditioner_if.sv
// input_conditioner_if: raw board pins in, conditioned levels and event pulses out.
interface input_conditioner_if;
  logic        btnL_raw;
  logic        btnR_raw;
  logic [15:0] switch_raw;
  logic        btnL;
  logic        btnR;
  logic [15:0] switch;
  logic        btnL_press;
  logic        btnR_press;
  logic        switch_changed;
  modport master (
    output btnL_raw, btnR_raw, switch_raw,
    input  btnL, btnR, switch, btnL_press, btnR_press, switch_changed
  );
  modport slave (
    input  btnL_raw, btnR_raw, switch_raw,
    output btnL, btnR, switch, btnL_press, btnR_press, switch_changed
  );
endinterface

// File: rtl/input_conditioner.sv
// input_conditioner: synchronises and debounces two buttons and 16 switches, with press/change pulses.
module input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input logic                clk,
  input logic                reset,
  input_conditioner_if.slave io
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);
  typedef enum logic [1:0] {LOW, RISE, HIGH, FALL} btn_state_e;
  // bit 16 = left button, bit 17 = right button, [15:0] = switches
  logic [SYNC_STAGES-1:0][17:0] sync_q;
  logic [17:0]                  s;
  logic [1:0]                   s_btn;
  logic [15:0]                  s_sw;
  btn_state_e                   st_q  [2];
  btn_state_e                   st_d  [2];
  logic [CW-1:0]                cnt_q [2];
  logic [CW-1:0]                cnt_d [2];
  logic [1:0]                   lvl_q, lvl_d, prs_q, prs_d;
  logic [15:0]                  sw_q, sw_d, cand_q, cand_d;
  logic [CW-1:0]                gcnt_q, gcnt_d;
  logic                         chg_q, chg_d;
  always_ff @(posedge clk or negedge reset)
    if (!reset) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], {io.btnR_raw, io.btnL_raw, io.switch_raw}};
  assign s     = sync_q[SYNC_STAGES-1];
  assign s_btn = s[17:16];
  assign s_sw  = s[15:0];
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    prs_d = '0;
    for (int i = 0; i < 2; i++) begin
      case (st_q[i])
        LOW:  if (s_btn[i]) begin
                st_d[i]  = RISE;
                cnt_d[i] = ONE;
              end
        RISE: if (!s_btn[i]) begin
                st_d[i]  = LOW;
                cnt_d[i] = '0;
              end else if (cnt_q[i] == LAST) begin
                st_d[i]  = HIGH;
                cnt_d[i] = '0;
                lvl_d[i] = 1'b1;
                prs_d[i] = 1'b1;
              end else cnt_d[i] = cnt_q[i] + ONE;
        HIGH: if (!s_btn[i]) begin
                st_d[i]  = FALL;
                cnt_d[i] = ONE;
              end
        FALL: if (s_btn[i]) begin
                st_d[i]  = HIGH;
                cnt_d[i] = '0;
              end else if (cnt_q[i] == LAST) begin
                st_d[i]  = LOW;
                cnt_d[i] = '0;
                lvl_d[i] = 1'b0;
              end else cnt_d[i] = cnt_q[i] + ONE;
      endcase
    end
  end
  // the whole switch vector shares one candidate, so any bit bouncing restarts the count
  always_comb begin
    sw_d   = sw_q;
    cand_d = cand_q;
    gcnt_d = gcnt_q;
    chg_d  = 1'b0;
    if (s_sw != sw_q) begin
      if (s_sw != cand_q) begin
        cand_d = s_sw;
        gcnt_d = ONE;
      end else if (gcnt_q == LAST) begin
        sw_d   = cand_q;
        chg_d  = 1'b1;
        gcnt_d = '0;
      end else gcnt_d = gcnt_q + ONE;
    end else begin
      gcnt_d = '0;
      cand_d = sw_q;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st_q   <= '{LOW, LOW};
      cnt_q  <= '{default: '0};
      lvl_q  <= '0;
      prs_q  <= '0;
      sw_q   <= '0;
      cand_q <= '0;
      gcnt_q <= '0;
      chg_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
      prs_q  <= prs_d;
      sw_q   <= sw_d;
      cand_q <= cand_d;
      gcnt_q <= gcnt_d;
      chg_q  <= chg_d;
    end
  assign io.btnL           = lvl_q[0];
  assign io.btnR           = lvl_q[1];
  assign io.btnL_press     = prs_q[0];
  assign io.btnR_press     = prs_q[1];
  assign io.switch         = sw_q;
  assign io.switch_changed = chg_q;
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed stimulus with a scoreboard of expected output events (SYNC=2, DEBOUNCE=4).
module tb_input_conditioner;
  logic clk = 1'b0;
  logic reset = 1'b0;
  input_conditioner_if bus();
  input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (.clk(clk), .reset(reset), .io(bus));
  always #5 clk = ~clk;
  typedef struct {
    int          cyc;
    logic        l;
    logic        r;
    logic [15:0] sw;
    logic [2:0]  p;
  } ev_t;
  ev_t         q[$];
  int          cyc = 0;
  int          checks = 0;
  int          passes = 0;
  logic [17:0] prev = '0;
  logic [17:0] cur;
  logic [2:0]  pul;
  ev_t         e;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask
  // an event is expected exactly SYNC+DEBOUNCE = 6 edges after the raw change is driven
  task automatic expect_ev(input logic l, input logic r, input logic [15:0] sw, input logic [2:0] p);
    q.push_back('{cyc + 6, l, r, sw, p});
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic drive(input logic l, input logic r, input logic [15:0] sw);
    bus.btnL_raw   = l;
    bus.btnR_raw   = r;
    bus.switch_raw = sw;
  endtask
  // monitor: any pulse or level change is an output event and must match the queue head
  initial forever begin
    @(posedge clk);
    #1;
    cur = {bus.btnL, bus.btnR, bus.switch};
    pul = {bus.btnL_press, bus.btnR_press, bus.switch_changed};
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      checks++;
      $display("FAIL event_missed: no event by cycle %0d, expected at cycle %0d", cyc, e.cyc);
    end
    if (pul != 3'b000 || cur != prev) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_event: levels %h pulses %b at cycle %0d, expected none", cur, pul, cyc);
      end else begin
        e = q.pop_front();
        check("event_cycle", cyc, e.cyc);
        check("event_levels", {14'd0, cur}, {14'd0, e.l, e.r, e.sw});
        check("event_pulses", {29'd0, pul}, {29'd0, e.p});
      end
    end
    prev = cur;
  end
  initial begin
    drive(1'b1, 1'b1, 16'hFFFF);
    tick(3);
    check("rst_btnL", {31'd0, bus.btnL}, 32'd0);
    check("rst_btnR", {31'd0, bus.btnR}, 32'd0);
    check("rst_switch", {16'd0, bus.switch}, 32'd0);
    check("rst_pulses", {29'd0, bus.btnL_press, bus.btnR_press, bus.switch_changed}, 32'd0);
    reset = 1'b1;
    expect_ev(1'b1, 1'b1, 16'hFFFF, 3'b111);
    tick(10);
    drive(1'b0, 1'b0, 16'h0000);
    expect_ev(1'b0, 1'b0, 16'h0000, 3'b001);
    tick(10);
    drive(1'b1, 1'b0, 16'h0000);
    expect_ev(1'b1, 1'b0, 16'h0000, 3'b100);
    tick(10);
    drive(1'b0, 1'b0, 16'h0000);
    expect_ev(1'b0, 1'b0, 16'h0000, 3'b000);
    tick(10);
    for (int i = 0; i < 4; i++) begin
      bus.btnR_raw = ~i[0];
      tick(2);
    end
    bus.btnR_raw = 1'b1;
    expect_ev(1'b0, 1'b1, 16'h0000, 3'b010);
    tick(10);
    bus.btnR_raw = 1'b0;
    expect_ev(1'b0, 1'b0, 16'h0000, 3'b000);
    tick(10);
    bus.switch_raw = 16'h00A5;
    expect_ev(1'b0, 1'b0, 16'h00A5, 3'b001);
    tick(10);
    bus.switch_raw = 16'h80A5;
    tick(3);
    bus.switch_raw = 16'h00A5;
    tick(10);
    check("glitch_switch", {16'd0, bus.switch}, 32'h0000_00A5);
    drive(1'b1, 1'b1, 16'h1234);
    expect_ev(1'b1, 1'b1, 16'h1234, 3'b111);
    tick(10);
    drive(1'b0, 1'b0, 16'h0000);
    expect_ev(1'b0, 1'b0, 16'h0000, 3'b001);
    tick(10);
    bus.btnL_raw = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    check("midrst_outputs", {13'd0, bus.btnL, bus.btnR, bus.btnL_press, bus.switch}, 32'd0);
    tick(1);
    reset = 1'b1;
    expect_ev(1'b1, 1'b0, 16'h0000, 3'b100);
    tick(10);
    check("queue_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/input_conditioner.md
# input_conditioner

Synchronises and debounces the raw FPGA board inputs (two push-buttons and 16 slide switches) before they reach the data-memory/IO decoder. Outputs are clean, glitch-free levels (`btnL`, `btnR`, `switch`) wired directly into the decoder's button and switch inputs. The block also produces one-cycle press pulses and a switch-change pulse for future interrupt or event logic. It sits between the board pins and the decoder, on the CPU clock.

## Interface
- `SYNC_STAGES`, 2, number of flip-flops in each input synchroniser chain; must be at least 2.
- `DEBOUNCE_CYCLES`, 1000000, consecutive stable cycles required before an output changes (10 ms at 100 MHz); must be at least 2.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `btnL_raw`  in  1  raw left button pin (LED-status button).
- `btnR_raw`  in  1  raw right button pin (switch-status button).
- `switch_raw`  in  16  raw slide-switch pins.
- `btnL`  out  1  debounced left button level.
- `btnR`  out  1  debounced right button level.
- `switch`  out  16  debounced switch vector.
- `btnL_press`  out  1  one-cycle pulse on a debounced 0→1 transition of `btnL`.
- `btnR_press`  out  1  one-cycle pulse on a debounced 0→1 transition of `btnR`.
- `switch_changed`  out  1  one-cycle pulse whenever `switch` takes a new value.

## Operation
- **Synchronisers:** each of the 18 raw bits passes through its own `SYNC_STAGES`-deep flip-flop chain. The chain output is called `s`. No other logic touches the raw pins.
- **Button debouncers:** each button has its own debouncer, built as a 4-state FSM with a counter `cnt`. The counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
  - **LOW:** output is 0. If `s`=1, go to RISE with `cnt`=1.
  - **RISE:** if `s`=0, return to LOW with `cnt`=0. If `s`=1 and `cnt`=`DEBOUNCE_CYCLES`-1, go to HIGH; the output becomes 1 and the press pulse fires for one cycle. Otherwise increment `cnt`.
  - **HIGH:** output is 1. If `s`=0, go to FALL with `cnt`=1.
  - **FALL:** if `s`=1, return to HIGH with `cnt`=0. If `s`=0 and `cnt`=`DEBOUNCE_CYCLES`-1, go to LOW with output 0 and no pulse. Otherwise increment `cnt`.
- **Switch debouncer:** one group debouncer covers the whole 16-bit vector.
  - It holds registers `cand` (candidate value) and `gcnt` (group counter).
  - If `s_sw` != `switch`, the vector is compared with `cand`:
    - If `s_sw` != `cand`, load `cand`=`s_sw` and set `gcnt`=1.
    - Otherwise increment `gcnt`. When `gcnt` reaches `DEBOUNCE_CYCLES`-1, commit `switch`=`cand`, pulse `switch_changed`, and clear `gcnt`.
  - If `s_sw` == `switch`, clear `gcnt` and set `cand`=`switch`.
- **Bounce handling:** any bounce, on either a button or any switch bit, restarts the relevant count. An output never changes on a glitch shorter than `DEBOUNCE_CYCLES` cycles.
- **Independence:** all three debouncers are independent. Simultaneous events produce simultaneous pulses, with no priority between them.

## Timing
- **Reset:** while `reset`=0, all outputs are 0. The synchroniser flops, `cand`, every counter and every FSM (held in LOW) are also 0. Reset asserts immediately and is released synchronously to `clk`.
- **Latency:** a clean input step that stays stable appears on the level output exactly `SYNC_STAGES` + `DEBOUNCE_CYCLES` rising edges after the raw change is sampled. The associated pulse fires on the same edge as the level change.
- **Pulse shape:** every pulse is exactly one cycle wide. A new pulse cannot occur sooner than 2×`DEBOUNCE_CYCLES` cycles after the previous one, because a full release and re-press are required.
- **Reset mid-count:** a reset during a count discards the count. After release, an input held at 1 is treated as a new press: full latency applies and the pulse fires.
- **Counter width:** the counters never wrap, since they are cleared on commit and restarted on mismatch.
- **Output drive:** outputs are registered, with no combinational path from any input to any output.

## Test plan
All scenarios use `SYNC_STAGES`=2 and `DEBOUNCE_CYCLES`=4.
- **Reset:** hold `reset`=0 with all raw inputs at 1 → all outputs are 0. Release reset → `btnL`, `btnR` and `switch`=16'hFFFF rise 6 cycles after release. `btnL_press`, `btnR_press` and `switch_changed` each pulse once.
- **Clean press and release:** `btnL_raw` goes 0→1 and is held → `btnL`=1 and `btnL_press`=1 exactly 6 edges later, and `btnL_press` is 0 on the following cycle. Release → `btnL`=0 after 6 edges, with no pulse.
- **Bounce:** `btnR_raw` toggles 1,0,1,0,1 with 2 cycles per level, then holds 1 → `btnR` rises only 6 cycles after the final rising edge, and exactly one `btnR_press` pulse fires.
- **Switch change and glitch:** `switch_raw`=16'h00A5 held → `switch`=16'h00A5 with one `switch_changed` pulse after 6 cycles. Next, a 3-cycle glitch of bit 15 → `switch` is unchanged and there is no pulse.
- **Simultaneous events:** both buttons and `switch_raw`=16'h1234 change on the same edge → all three pulses fire on the same cycle.
- **Reset mid-count:** assert reset 3 cycles into a `btnL` count, release it after 2 cycles while `btnL_raw` is still 1 → `btnL` rises 6 cycles after release.
